// File: rtl/led_pattern_sequencer_pkg.sv
// Shared constants for the LED pattern sequencer:
// mode encoding, initial patterns and board I/O bit positions.
package led_pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    localparam logic [3:0] PAT_BLINK  = 4'b0000;
    localparam logic [3:0] PAT_CHASE  = 4'b0001;
    localparam logic [3:0] PAT_BOUNCE = 4'b0001;
    localparam logic [3:0] PAT_COUNT  = 4'b0000;

    localparam int SW_RUN   = 0;
    localparam int SW_SPD   = 1;
    localparam int SW_DIR   = 3;
    localparam int BTN_MODE = 0;
    localparam int BTN_STEP = 1;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

    function automatic logic [3:0] init_pat(input mode_t m);
        logic [3:0] p;
        unique case (m)
            MODE_BLINK:  p = PAT_BLINK;
            MODE_CHASE:  p = PAT_CHASE;
            MODE_BOUNCE: p = PAT_BOUNCE;
            MODE_COUNT:  p = PAT_COUNT;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Board-side bundle: switches and buttons in, LEDs and status out.
// master = board/test side, slave = sequencer.
interface led_pattern_sequencer_if;
    logic [3:0] sw;
    logic [3:0] btn;
    logic [3:0] led;
    logic [1:0] mode;
    logic       step;

    modport master (output sw, btn, input led, mode, step);
    modport slave  (input sw, btn, output led, mode, step);
endinterface

// File: rtl/led_pattern_sequencer_btn_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle pulse
// when the accepted level rises.
module btn_debounce #(
    parameter int DEB_CYCLES = 1250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          meta;
    logic          sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            meta  <= btn;
            sync  <= meta;
            press <= 1'b0;
            // cnt tracks how long sync has disagreed with the accepted level
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync;
                cnt   <= '0;
                press <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// Scheduled LED pattern engine: prescaled steps, four pattern modes,
// debounced mode-advance and single-step buttons.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int CLK_HZ     = 125000000,
    parameter int TICK_HZ    = 8,
    parameter int DEB_CYCLES = 1250000
) (
    input logic                    clk,
    input logic                    rst,
    led_pattern_sequencer_if.slave io
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int BW       = $clog2(TICK_DIV);

    logic [3:0]    sw_meta;
    logic [3:0]    sw_s;
    logic [BW-1:0] base_cnt;
    logic [2:0]    scale_cnt;
    mode_t         mode_q;
    logic [3:0]    led_q;
    logic          dir_q;
    logic          step_q;

    logic       mode_press;
    logic       step_press;
    logic       run;
    logic [1:0] speed;
    logic       dir_sw;
    logic [3:0] scale_lim;
    logic       base_tick;
    logic       scale_term;
    logic       step_ev;
    logic [3:0] next_led;
    logic       next_dir;
    logic       unused_btn;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (io.btn[BTN_MODE]),
        .press (mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst   (rst),
        .btn   (io.btn[BTN_STEP]),
        .press (step_press)
    );

    assign unused_btn = ^io.btn[3:2];

    assign run        = sw_s[SW_RUN];
    assign speed      = sw_s[SW_SPD +: 2];
    assign dir_sw     = sw_s[SW_DIR];
    assign scale_lim  = (4'd1 << speed) - 4'd1;
    assign base_tick  = run && (base_cnt == BW'(TICK_DIV - 1));
    // >= so a speed reduction mid-interval fires on the next base tick
    assign scale_term = {1'b0, scale_cnt} >= scale_lim;
    assign step_ev    = (base_tick && scale_term) || (step_press && !run);

    always_comb begin
        next_led = led_q;
        next_dir = dir_q;
        unique case (mode_q)
            MODE_BLINK:  next_led = ~led_q;
            MODE_CHASE:  next_led = dir_sw ? {led_q[0], led_q[3:1]}
                                           : {led_q[2:0], led_q[3]};
            MODE_BOUNCE: begin
                if (led_q[3]) next_dir = 1'b0;
                else if (led_q[0]) next_dir = 1'b1;
                next_led = next_dir ? (led_q << 1) : (led_q >> 1);
            end
            MODE_COUNT:  next_led = dir_sw ? led_q - 4'd1 : led_q + 4'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta   <= '0;
            sw_s      <= '0;
            base_cnt  <= '0;
            scale_cnt <= '0;
            mode_q    <= MODE_BLINK;
            led_q     <= PAT_BLINK;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
        end else begin
            sw_meta <= io.sw;
            sw_s    <= sw_meta;
            step_q  <= 1'b0;
            if (mode_press) begin
                mode_q    <= next_mode(mode_q);
                led_q     <= init_pat(next_mode(mode_q));
                dir_q     <= 1'b1;
                base_cnt  <= '0;
                scale_cnt <= '0;
            end else begin
                if (base_tick) begin
                    base_cnt  <= '0;
                    scale_cnt <= scale_term ? 3'd0 : scale_cnt + 3'd1;
                end else if (run) begin
                    base_cnt <= base_cnt + 1'b1;
                end
                if (step_ev) begin
                    step_q <= 1'b1;
                    led_q  <= next_led;
                    dir_q  <= next_dir;
                end
            end
        end
    end

    assign io.led  = led_q;
    assign io.mode = mode_q;
    assign io.step = step_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a tiny clock ratio
// (TICK_DIV=4, DEB_CYCLES=3).
module tb_led_pattern_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    led_pattern_sequencer_if io();

    led_pattern_sequencer #(
        .CLK_HZ     (16),
        .TICK_HZ    (4),
        .DEB_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_step(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (io.step === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_mode(input logic [1:0] m, input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (io.mode === m) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic press(input int idx, input int n);
        io.btn[idx] = 1'b1;
        repeat (n) @(negedge clk);
        io.btn[idx] = 1'b0;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        io.sw  = 4'b0000;
        io.btn = 4'b0000;
        idle(3);
        total++;
        if (io.led !== 4'b0000) $display("FAIL reset_led got %b want 0000", io.led);
        else passed++;
        total++;
        if (io.mode !== 2'd0) $display("FAIL reset_mode got %0d want 0", io.mode);
        else passed++;
        total++;
        if (io.step !== 1'b0) $display("FAIL reset_step got %b want 0", io.step);
        else passed++;
        io.sw = 4'b0001;
        idle(3);
        total++;
        if (io.led !== 4'b0000) $display("FAIL reset_hold_led got %b want 0000", io.led);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_blink;
        int c;
        wait_step(20, c);
        total++;
        if (c < 0 || io.led !== 4'b1111) $display("FAIL blink_1 cyc %0d led %b want 1111", c, io.led);
        else passed++;
        wait_step(8, c);
        total++;
        if (c != 4) $display("FAIL blink_gap1 got %0d want 4", c);
        else passed++;
        total++;
        if (io.led !== 4'b0000) $display("FAIL blink_2 got %b want 0000", io.led);
        else passed++;
        wait_step(8, c);
        total++;
        if (c != 4 || io.led !== 4'b1111) $display("FAIL blink_3 cyc %0d led %b want 4/1111", c, io.led);
        else passed++;
    endtask

    task automatic test_chase;
        int c;
        logic [3:0] exp_l [4];
        exp_l = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        press(0, 5);
        wait_mode(2'd1, 10, c);
        total++;
        if (c < 0) $display("FAIL chase_mode got %0d want 1", io.mode);
        else passed++;
        total++;
        if (io.led !== 4'b0001 || io.step !== 1'b0)
            $display("FAIL chase_init led %b step %b want 0001/0", io.led, io.step);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            wait_step(8, c);
            total++;
            if (c < 0 || io.led !== exp_l[i])
                $display("FAIL chase_left%0d cyc %0d led %b want %b", i, c, io.led, exp_l[i]);
            else passed++;
        end
        io.sw = 4'b1001;
        wait_step(8, c);
        total++;
        if (c < 0 || io.led !== 4'b1000) $display("FAIL chase_right cyc %0d led %b want 1000", c, io.led);
        else passed++;
    endtask

    task automatic test_speed;
        int c;
        io.sw = 4'b0111;
        for (int i = 0; i < 2; i++) begin
            wait_step(40, c);
            total++;
            if (c != 32) $display("FAIL speed3_gap%0d got %0d want 32", i, c);
            else passed++;
        end
        idle(12);
        io.sw = 4'b0011;
        wait_step(12, c);
        total++;
        if (c < 1 || c > 8) $display("FAIL speed_drop got %0d want 1..8", c);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            wait_step(12, c);
            total++;
            if (c != 8) $display("FAIL speed1_gap%0d got %0d want 8", i, c);
            else passed++;
        end
    endtask

    task automatic test_bounce_count;
        int c;
        logic [3:0] exp_b [7];
        exp_b = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        io.sw = 4'b1001;
        idle(4);
        press(0, 5);
        wait_mode(2'd2, 10, c);
        total++;
        if (c < 0 || io.led !== 4'b0001) $display("FAIL bounce_init mode %0d led %b want 2/0001", io.mode, io.led);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            wait_step(8, c);
            total++;
            if (c < 0 || io.led !== exp_b[i])
                $display("FAIL bounce_%0d cyc %0d led %b want %b", i, c, io.led, exp_b[i]);
            else passed++;
        end
        press(0, 5);
        wait_mode(2'd3, 10, c);
        total++;
        if (c < 0 || io.led !== 4'b0000) $display("FAIL count_init mode %0d led %b want 3/0000", io.mode, io.led);
        else passed++;
        wait_step(8, c);
        total++;
        if (c < 0 || io.led !== 4'b1111) $display("FAIL count_dn1 cyc %0d led %b want 1111", c, io.led);
        else passed++;
        wait_step(8, c);
        total++;
        if (c < 0 || io.led !== 4'b1110) $display("FAIL count_dn2 cyc %0d led %b want 1110", c, io.led);
        else passed++;
    endtask

    task automatic test_pause_collide;
        int c;
        logic [3:0] prev;
        logic [3:0] expv;
        logic seen;
        io.sw = 4'b0000;
        idle(3);
        prev = io.led;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (io.step === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || io.led !== prev)
            $display("FAIL pause_frozen step_seen %b led %b want 0/%b", seen, io.led, prev);
        else passed++;
        press(1, 2);
        repeat (10) begin
            @(negedge clk);
            if (io.step === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || io.led !== prev)
            $display("FAIL glitch_ignored step_seen %b led %b want 0/%b", seen, io.led, prev);
        else passed++;
        expv = prev + 4'd1;
        press(1, 5);
        wait_step(15, c);
        total++;
        if (c < 0 || io.led !== expv) $display("FAIL single_step cyc %0d led %b want %b", c, io.led, expv);
        else passed++;
        idle(8);
        io.sw = 4'b0001;
        wait_step(20, c);
        wait_step(8, c);
        total++;
        if (c != 4) $display("FAIL resume_gap got %0d want 4", c);
        else passed++;
        idle(2);
        press(0, 5);
        @(negedge clk);
        total++;
        if (io.mode !== 2'd0 || io.step !== 1'b0 || io.led !== 4'b0000)
            $display("FAIL collide mode %0d step %b led %b want 0/0/0000", io.mode, io.step, io.led);
        else passed++;
        wait_step(8, c);
        total++;
        if (c != 4 || io.led !== 4'b1111) $display("FAIL collide_next cyc %0d led %b want 4/1111", c, io.led);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int c;
        logic [3:0] last;
        logic found;
        idle(8);
        press(0, 5);
        wait_mode(2'd1, 10, c);
        idle(8);
        press(0, 5);
        wait_mode(2'd2, 10, c);
        total++;
        if (c < 0) $display("FAIL mid_mode got %0d want 2", io.mode);
        else passed++;
        last  = io.led;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            wait_step(8, c);
            if (c < 0) break;
            if (last == 4'b1000 && io.led == 4'b0100) found = 1'b1;
            last = io.led;
        end
        total++;
        if (found !== 1'b1) $display("FAIL mid_heading_down got %b want 1", found);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (io.led !== 4'b0000 || io.mode !== 2'd0 || io.step !== 1'b0)
            $display("FAIL mid_reset led %b mode %0d step %b want 0000/0/0", io.led, io.mode, io.step);
        else passed++;
        wait_step(20, c);
        total++;
        if (c < 0 || io.led !== 4'b1111) $display("FAIL after_rst_1 cyc %0d led %b want 1111", c, io.led);
        else passed++;
        wait_step(8, c);
        total++;
        if (c != 4 || io.led !== 4'b0000) $display("FAIL after_rst_2 cyc %0d led %b want 4/0000", c, io.led);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_blink();
        test_chase();
        test_speed();
        test_bounce_count();
        test_pause_collide();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Controller for the ZYBO LED blink datapath. It turns the free-running 125 MHz counter idea into a scheduled pattern engine. A prescaler generates step events at a switch-selected rate. An FSM sequences four LED patterns. Debounced buttons change mode and single-step the pattern while paused. It sits at board top level, driving led[3:0] directly from sw/btn.

Parameters:
CLK_HZ, 125000000, input clock frequency in Hz
TICK_HZ, 8, base step rate at speed 0; TICK_DIV = CLK_HZ/TICK_HZ; must divide evenly and be >= 2
DEB_CYCLES, 1250000, number of cycles a button must stay stable to be accepted (10 ms)

Ports:
clk  in  1  system clock, 125 MHz
rst  in  1  synchronous, active-high reset
sw  in  4  sw[0] run; sw[2:1] speed; sw[3] direction; asynchronous board input
btn  in  4  btn[0] mode advance; btn[1] single step; btn[3:2] unused; asynchronous board input
led  out  4  registered pattern output
mode  out  2  current mode: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT
step  out  1  one-cycle pulse, high in the first cycle led shows a new step value

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. Reset drives led=0000, mode=BLINK, step=0, bounce direction=up, and clears all counters, synchronizers and debounce state. Reset mid-operation has the same effect one edge later. A pending step or button press is discarded.
- Input synchronization: sw and btn each pass through a 2-FF synchronizer. All internal logic uses the synchronized values.
- Debounce (btn[0], btn[1]):
  - A candidate level must stay stable for DEB_CYCLES consecutive cycles before it is accepted.
  - A 0->1 change of the accepted level emits a one-cycle press pulse.
  - Pulses shorter than DEB_CYCLES are ignored. Release produces no pulse.
- Prescaler, counting while run=1:
  - base counter counts 0..TICK_DIV-1; base_tick fires at terminal, then the counter wraps to 0.
  - scale counter counts base_ticks 0..(2^speed)-1. At terminal it raises step_req and wraps.
  - step period = TICK_DIV * 2^speed cycles.
  - The scale terminal test uses >=, so lowering speed mid-interval takes effect at the next base_tick.
  - When run=0, both counters hold their values (no clear).
- Step sources:
  - step_req from the prescaler.
  - btn[1] press, accepted only when run=0. Ignored when run=1.
- Mode FSM (BLINK -> CHASE -> BOUNCE -> COUNT -> BLINK):
  - Advances on a btn[0] press.
  - On a mode change, led loads the mode's initial pattern on the next edge, both prescaler counters clear, and step stays 0.
  - Initial patterns: BLINK 0000; CHASE 0001; BOUNCE 0001 with direction up; COUNT 0000.
- Simultaneous events: a mode press and a step in the same cycle → the mode change wins and the step is dropped.
- Pattern update: led updates on the edge after the step event; step=1 for exactly that following cycle.
  - BLINK: led <= ~led.
  - CHASE: one-hot rotate. sw[3]=0 rotates left (0001->0010, 1000->0001); sw[3]=1 rotates right (0001->1000).
  - BOUNCE: one-hot shift in the current direction. At 1000 the direction flips to down; at 0001 it flips to up. The flip happens on the same step, so the ends are never held twice. sw[3] is ignored.
  - COUNT: led +1 when sw[3]=0, -1 when sw[3]=1. Modulo 16, wrapping 1111<->0000.
- Width rule: the base counter is $clog2(TICK_DIV) bits; the scale counter is 3 bits; the debounce counter is $clog2(DEB_CYCLES+1) bits.

Decomposition:
- Shared package: mode encoding constants (MODE_BLINK..MODE_COUNT), initial pattern constants, switch/button index constants.
- One sub-module, btn_debounce (parameter DEB_CYCLES), containing the 2-FF synchronizer, stability counter and press pulse. Instantiated twice.
- Prescaler and FSM stay in the top block.

Test Plan (CLK_HZ=16, TICK_HZ=4 → TICK_DIV=4; DEB_CYCLES=3):
1. Reset, then sw=0001 → mode=0. led toggles 0000->1111->0000 with exactly 4 cycles between step pulses. led stays 0000 during reset.
2. Press btn[0] for 5 cycles → mode=1, led=0001. Steps then give 0010, 0100, 1000, 0001. Set sw[3]=1 → next step goes 0001->1000.
3. CHASE with sw=0111 (speed 3) → step pulses exactly 32 cycles apart. Switch to sw=0011 mid-interval → next step within 8 cycles, then every 8.
4. BOUNCE mode → led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. COUNT with sw[3]=1 from 0000 → 1111, 1110.
5. sw[0]=0 in COUNT → led frozen; a 2-cycle btn[1] glitch gives no step. A 5-cycle btn[1] press gives one step (+1). btn[0] and a prescaler step in the same cycle → mode changes, no step pulse.
6. Assert rst for 1 cycle mid-run in BOUNCE heading down → next cycle led=0000, mode=0, step=0. After release, behaviour matches scenario 1.
